// File: rtl/usb_tx_encoder.sv
// USB full-speed TX line encoder: LSB-first byte shifter, bit stuffing, NRZI and EOP generation.
// Define USB_TX_STUFF_EN to enable bit stuffing; without it bits are NRZI-encoded raw (loopback/eye tests).
module usb_tx_encoder #(
  parameter int STUFF_LIMIT  = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bit_strobe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       eop_req,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       busy,
  output logic       stuffing,
  output logic       underrun
);

  localparam int EW = (EOP_SE0_BITS < 2) ? 1 : $clog2(EOP_SE0_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_STUFF, S_EOP_SE0, S_EOP_J} state_t;

  if (STUFF_LIMIT < 1 || STUFF_LIMIT > 7 || EOP_SE0_BITS < 1) begin : g_param_check
    $error("STUFF_LIMIT must be 1..7 and EOP_SE0_BITS at least 1");
  end

  state_t        r_state, w_state_next;
  logic [7:0]    r_hold, w_hold_next;
  logic          r_hold_full, w_hold_full_next;
  logic [7:0]    r_shift, w_shift_next;
  logic [2:0]    r_idx, w_idx_next;
  logic [EW-1:0] r_eop_cnt, w_eop_cnt_next;
  logic          r_line_j, w_line_j_next;   // NRZI reference level: 1 = J, 0 = K
  logic          r_dp, w_dp_next;
  logic          r_dm, w_dm_next;
  logic          r_busy, w_busy_next;
  logic          r_stuffing, w_stuffing_next;
  logic          r_underrun, w_underrun_next;

  logic w_stuff_due, w_in_stream, w_go_stuff, w_more_bits;
  logic w_next_bit, w_reload, w_end, w_bit, w_eop_done;

`ifdef USB_TX_STUFF_EN
  logic [2:0] r_ones, w_ones_next;
  assign w_stuff_due = (r_ones == 3'(STUFF_LIMIT));
`else
  assign w_stuff_due = 1'b0;
`endif

  // STUFF resumes at the "next data bit" rule, so it shares the stream decode with SHIFT.
  assign w_more_bits = (r_idx != 3'd0);
  assign w_in_stream = ((r_state == S_SHIFT) && !w_stuff_due) || (r_state == S_STUFF);
  assign w_go_stuff  = (r_state == S_SHIFT) && w_stuff_due;
  assign w_next_bit  = w_in_stream && w_more_bits;
  assign w_reload    = r_hold_full && ((r_state == S_IDLE) || (w_in_stream && !w_more_bits));
  assign w_end       = w_in_stream && !w_more_bits && !r_hold_full;
  assign w_bit       = w_reload ? r_hold[0] : r_shift[r_idx];
  assign w_eop_done  = (r_eop_cnt == EW'(EOP_SE0_BITS));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (bit_strobe) begin
      case (r_state)
        S_IDLE:    if (r_hold_full) w_state_next = S_SHIFT;
        S_SHIFT: begin
          if (w_go_stuff)  w_state_next = S_STUFF;
          else if (w_end)  w_state_next = S_EOP_SE0;
        end
        S_STUFF:   w_state_next = w_end ? S_EOP_SE0 : S_SHIFT;
        S_EOP_SE0: if (w_eop_done) w_state_next = S_EOP_J;
        S_EOP_J:   w_state_next = S_IDLE;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_hold_next      = r_hold;
    w_hold_full_next = r_hold_full;
    w_shift_next     = r_shift;
    w_idx_next       = r_idx;
    w_eop_cnt_next   = r_eop_cnt;
    w_line_j_next    = r_line_j;
    w_dp_next        = r_dp;
    w_dm_next        = r_dm;
    w_busy_next      = r_busy;
    w_stuffing_next  = r_stuffing;
    w_underrun_next  = 1'b0;
`ifdef USB_TX_STUFF_EN
    w_ones_next      = r_ones;
`endif
    if (bit_strobe) begin
      w_busy_next     = (w_state_next != S_IDLE);
      w_stuffing_next = w_go_stuff;
      if (w_reload || w_next_bit) begin
        w_shift_next  = w_reload ? r_hold : r_shift;
        w_idx_next    = w_reload ? 3'd1 : r_idx + 3'd1;
        w_line_j_next = w_bit ? r_line_j : !r_line_j;
        w_dp_next     = w_line_j_next;
        w_dm_next     = !w_line_j_next;
        if (w_reload) w_hold_full_next = 1'b0;
`ifdef USB_TX_STUFF_EN
        w_ones_next   = !w_bit ? 3'd0 : (w_stuff_due ? r_ones : r_ones + 3'd1);
`endif
      end else if (w_go_stuff) begin
        w_line_j_next = !r_line_j;
        w_dp_next     = !r_line_j;
        w_dm_next     = r_line_j;
`ifdef USB_TX_STUFF_EN
        w_ones_next   = 3'd0;
`endif
      end else if (w_end) begin
        w_eop_cnt_next  = EW'(1);
        w_dp_next       = 1'b0;
        w_dm_next       = 1'b0;
        w_underrun_next = !eop_req;
      end else if (r_state == S_EOP_SE0) begin
        if (w_eop_done) begin
          w_line_j_next = 1'b1;
          w_dp_next     = 1'b1;
          w_dm_next     = 1'b0;
        end else begin
          w_eop_cnt_next = r_eop_cnt + EW'(1);
          w_dp_next      = 1'b0;
          w_dm_next      = 1'b0;
        end
      end else if (r_state == S_EOP_J) begin
        w_line_j_next = 1'b1;
        w_dp_next     = 1'b1;
        w_dm_next     = 1'b0;
`ifdef USB_TX_STUFF_EN
        w_ones_next   = 3'd0;
`endif
      end
    end
    // Decisions above use the pre-edge holding state; a byte accepted now is seen next strobe.
    if (tx_valid && !r_hold_full) begin
      w_hold_next      = tx_data;
      w_hold_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_hold      <= 8'd0;
      r_hold_full <= 1'b0;
      r_shift     <= 8'd0;
      r_idx       <= 3'd0;
      r_eop_cnt   <= '0;
      r_line_j    <= 1'b1;
      r_dp        <= 1'b1;
      r_dm        <= 1'b0;
      r_busy      <= 1'b0;
      r_stuffing  <= 1'b0;
      r_underrun  <= 1'b0;
`ifdef USB_TX_STUFF_EN
      r_ones      <= 3'd0;
`endif
    end else begin
      r_hold      <= w_hold_next;
      r_hold_full <= w_hold_full_next;
      r_shift     <= w_shift_next;
      r_idx       <= w_idx_next;
      r_eop_cnt   <= w_eop_cnt_next;
      r_line_j    <= w_line_j_next;
      r_dp        <= w_dp_next;
      r_dm        <= w_dm_next;
      r_busy      <= w_busy_next;
      r_stuffing  <= w_stuffing_next;
      r_underrun  <= w_underrun_next;
`ifdef USB_TX_STUFF_EN
      r_ones      <= w_ones_next;
`endif
    end
  end

  assign tx_ready   = !r_hold_full;
  assign dplus_out  = r_dp;
  assign dminus_out = r_dm;
  assign busy       = r_busy;
  assign stuffing   = r_stuffing;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder: queue-based line model, directed packets and random traffic.
// Follows USB_TX_STUFF_EN the same way as the design.
module tb_usb_tx_encoder;

  localparam int LIMIT    = 6;
  localparam int SE0_BITS = 2;
`ifdef USB_TX_STUFF_EN
  localparam bit STUFF_EN = 1'b1;
`else
  localparam bit STUFF_EN = 1'b0;
`endif
  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       bit_strobe = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       eop_req = 1'b0;
  logic       tx_ready, dplus_out, dminus_out, busy, stuffing, underrun;

  usb_tx_encoder #(.STUFF_LIMIT(LIMIT), .EOP_SE0_BITS(SE0_BITS)) dut (
    .clk(clk), .n_rst(n_rst), .bit_strobe(bit_strobe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .eop_req(eop_req), .dplus_out(dplus_out), .dminus_out(dminus_out),
    .busy(busy), .stuffing(stuffing), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the packet is a queue of logical bits, the EOP a queue of line symbols (0 SE0, 1 J, 2 J+idle).
  bit         m_hold_full;
  logic [7:0] m_hold_byte;
  bit         m_active;
  bit         m_bits[$];
  int         m_eop_q[$];
  int         m_run;
  bit         m_level_j;
  logic [1:0] m_line;
  bit         m_busy, m_stuffing, m_underrun;

  bit    cap_en = 1'b0;
  string cap_s;
  int    cap_under, cap_stuff;

  logic [7:0] pkt_q[$];
  int  pkt_idx = 0;
  bit  pkt_eop = 1'b0;
  int  pkt_no = 0;
  int  valid_pct = 100;
  int  strobe_period = 4;
  int  strobe_cnt = 0;

  function automatic string sym_str(input logic [1:0] l);
    case (l)
      LJ:      return "J";
      LK:      return "K";
      LSE0:    return "0";
      default: return "?";
    endcase
  endfunction

  task automatic model_reset();
    m_hold_full = 1'b0; m_hold_byte = 8'd0; m_active = 1'b0;
    m_bits.delete(); m_eop_q.delete();
    m_run = 0; m_level_j = 1'b1; m_line = LJ;
    m_busy = 1'b0; m_stuffing = 1'b0; m_underrun = 1'b0;
  endtask

  task automatic emit_bit(input bit b);
    if (!b) m_level_j = !m_level_j;
    m_run  = b ? ((m_run < LIMIT) ? m_run + 1 : m_run) : 0;
    m_line = m_level_j ? LJ : LK;
  endtask

  task automatic load_byte(input logic [7:0] v);
    m_bits.delete();
    for (int i = 0; i < 8; i++) m_bits.push_back(v[i]);
    m_hold_full = 1'b0;
  endtask

  task automatic model_step();
    bit         was_full;
    logic [7:0] was_byte;
    bit         busy_before;
    int         s;
    was_full    = m_hold_full;
    was_byte    = m_hold_byte;
    busy_before = m_busy;
    m_underrun  = 1'b0;
    if (bit_strobe) begin
      m_stuffing = 1'b0;
      if (m_eop_q.size() > 0) begin
        s = m_eop_q.pop_front();
        if (s == 0) m_line = LSE0;
        else begin
          m_line = LJ; m_level_j = 1'b1;
          if (s == 2) m_run = 0;
        end
      end else if (!m_active) begin
        if (was_full) begin
          m_active = 1'b1;
          load_byte(was_byte);
          emit_bit(m_bits.pop_front());
        end else m_line = LJ;
      end else if (STUFF_EN && m_run == LIMIT) begin
        m_level_j  = !m_level_j;
        m_run      = 0;
        m_stuffing = 1'b1;
        m_line     = m_level_j ? LJ : LK;
      end else if (m_bits.size() > 0) begin
        emit_bit(m_bits.pop_front());
      end else if (was_full) begin
        load_byte(was_byte);
        emit_bit(m_bits.pop_front());
      end else begin
        m_underrun = !eop_req;
        m_active   = 1'b0;
        m_line     = LSE0;
        for (int i = 1; i < SE0_BITS; i++) m_eop_q.push_back(0);
        m_eop_q.push_back(1);
        m_eop_q.push_back(2);
      end
      m_busy = m_active || (m_eop_q.size() > 0);
      if (cap_en) begin
        if (busy_before || m_busy) cap_s = {cap_s, sym_str(m_line)};
        cap_under += int'(m_underrun);
        cap_stuff += int'(m_stuffing);
      end
    end
    if (tx_valid && !was_full) begin
      m_hold_full = 1'b1;
      m_hold_byte = tx_data;
    end
  endtask

  task automatic check_outputs();
    logic [5:0] act, exp;
    act = {tx_ready, dplus_out, dminus_out, busy, stuffing, underrun};
    exp = {!m_hold_full, m_line, m_busy, m_stuffing, m_underrun};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL outputs t=%0t actual=%b required=%b (ready,d+,d-,busy,stuffing,underrun)", $time, act, exp);
    end
  endtask

  task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_pat(input string name, input string exp);
    n_checks++;
    if (cap_s != exp) begin
      n_fail++;
      $display("FAIL %s: line symbols actual=%s required=%s", name, cap_s, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare away from the edge.
  task automatic tick();
    bit accepted;
    bit_strobe = (strobe_cnt == 0);
    strobe_cnt = bit_strobe ? strobe_period - 1 : strobe_cnt - 1;
    tx_valid   = (pkt_idx < pkt_q.size()) && ($urandom_range(0, 99) < valid_pct);
    tx_data    = tx_valid ? pkt_q[pkt_idx] : 8'($urandom);
    eop_req    = pkt_eop && (pkt_idx >= pkt_q.size());
    @(posedge clk);
    if (n_rst) begin
      accepted = tx_valid && !m_hold_full;
      model_step();
      if (accepted) pkt_idx++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_packet(input int budget);
    int cyc;
    cyc = 0;
    pkt_idx = 0;
    while (!(pkt_idx >= pkt_q.size() && !m_hold_full && !m_busy) && cyc < budget) begin
      tick();
      cyc++;
    end
    if (cyc >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL packet_timeout: packet %0d not finished after %0d cycles", pkt_no, cyc);
    end
    $display("packet %0d: %0d bytes eop_req=%0b valid_pct=%0d strobe_period=%0d cycles=%0d",
             pkt_no, pkt_q.size(), pkt_eop, valid_pct, strobe_period, cyc);
    pkt_no++;
    pkt_q.delete();
    pkt_eop = 1'b0;
    pkt_idx = 0;
  endtask

  task automatic directed(input string name, input string pat, input int exp_under, input int exp_stuff);
    cap_s = ""; cap_under = 0; cap_stuff = 0; cap_en = 1'b1;
    valid_pct = 100;
    run_packet(2000);
    cap_en = 1'b0;
    check_pat(name, pat);
    check_lit({name, "_underrun_pulses"}, 8'(cap_under), 8'(exp_under));
    check_lit({name, "_stuff_bits"}, 8'(cap_stuff), 8'(exp_stuff));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string pat_sync, pat_ff00, pat_3f00;
    int    n;
    pat_sync = "KJKJKJKK00JJ";
`ifdef USB_TX_STUFF_EN
    pat_ff00 = {"KJKJKJKK", "KKKKK", "J", "JJJ", "KJKJKJKJ", "00JJ"};
    pat_3f00 = {"JJJJJJ", "K", "JK", "JKJKJKJK", "00JJ"};
`else
    pat_ff00 = {"KJKJKJKK", "KKKKKKKK", "JKJKJKJK", "00JJ"};
    pat_3f00 = {"JJJJJJ", "KJ", "KJKJKJKJ", "00JJ"};
`endif
    model_reset();
    #1 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check_lit("reset_state", 8'({tx_ready, dplus_out, dminus_out, busy, stuffing, underrun}), 8'b0011_0000);
    n_rst = 1'b1;

    strobe_period = 4; strobe_cnt = 0;
    repeat (80) tick();
    check_lit("idle_20_strobes", 8'({tx_ready, dplus_out, dminus_out, busy, stuffing, underrun}), 8'b0011_0000);

    pkt_q = '{8'h80}; pkt_eop = 1'b1;
    directed("sync_eop", pat_sync, 0, 0);
    pkt_q = '{8'h80, 8'hFF, 8'h00}; pkt_eop = 1'b1;
    directed("sync_ff_00", pat_ff00, 0, STUFF_EN ? 1 : 0);
    pkt_q = '{8'h3F, 8'h00}; pkt_eop = 1'b1;
    directed("3f_00", pat_3f00, 0, STUFF_EN ? 1 : 0);
    pkt_q = '{8'h80}; pkt_eop = 1'b0;
    directed("underrun", pat_sync, 1, 0);

    // Abort a packet mid-byte, then confirm the next one starts from J.
    pkt_q = '{8'h00, 8'h00}; pkt_eop = 1'b1; pkt_idx = 0; valid_pct = 100;
    repeat (20) tick();
    check_lit("busy_before_abort", 8'(busy), 8'd1);
    #2 n_rst = 1'b0;
    #1 check_lit("reset_mid_packet", 8'({tx_ready, dplus_out, dminus_out, busy, stuffing, underrun}), 8'b0011_0000);
    model_reset();
    pkt_q.delete(); pkt_eop = 1'b0; pkt_idx = 0;
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (8) tick();
    pkt_q = '{8'h80}; pkt_eop = 1'b1;
    directed("sync_after_reset", pat_sync, 0, 0);

    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, 5);
      strobe_period = $urandom_range(1, 6);
      case ($urandom_range(0, 3))
        0:       valid_pct = 100;
        1:       valid_pct = 60;
        2:       valid_pct = 25;
        default: valid_pct = 4;
      endcase
      pkt_eop = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < n; i++)
        pkt_q.push_back(($urandom_range(0, 9) < 3) ? 8'hFF : 8'($urandom));
      run_packet(4000);
      repeat ($urandom_range(0, 10)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
